// File: rtl/bsr_mmio_uart.sv
// MMIO-mapped 8N1 UART target: 16-byte register window, TX FIFO + serializer,
// RX deserializer with a one-byte holding register, programmable baud divisor.
module bsr_mmio_uart #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_E010,
  parameter int          TXF_LOG2  = 4,
  parameter logic [15:0] DIV_INIT  = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mmioAddr,
  input  logic [4:0]  mmioOpm,
  input  logic [31:0] mmioInData,
  output logic [31:0] mmioOutData,
  output logic [1:0]  mmioOK,
  output logic        uartTx,
  input  logic        uartRx
);
  localparam logic [1:0] OK_READY = 2'b00, OK_OK = 2'b01, OK_HOLD = 2'b10, OK_FAULT = 2'b11;
  localparam int TXF_DEPTH = 1 << TXF_LOG2;
  localparam logic [TXF_LOG2:0] TXF_FULL = (TXF_LOG2+1)'(TXF_DEPTH);

  typedef enum logic {BUS_IDLE, BUS_DONE} bus_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_e;

  bus_e        bus_q, bus_d;
  logic        fault_q, fault_d, wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d, rd_mux, status;
  logic [15:0] div_q;
  logic        req, acc, is_wr, is_rd;
  logic [1:0]  sel;
  logic        wr_data, wr_stat, wr_div, rd_data;

  logic [7:0]          txf_mem [TXF_DEPTH];
  logic [TXF_LOG2-1:0] txf_wp_q, txf_rp_q;
  logic [TXF_LOG2:0]   txf_cnt_q;
  logic                tx_full, tx_empty, push, drop, pop, tx_last;
  logic                tx_busy_q, tx_drop_q;
  logic [9:0]          tx_sh_q;
  logic [15:0]         tx_cnt_q, tx_div_q;
  logic [3:0]          tx_bit_q;

  rx_e         rx_st_q, rx_st_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall, rx_ok, rx_err;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [16:0] rx_div_p1;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q;
  logic        rx_vld_q, rx_ovr_q, rx_ferr_q;
  logic        unused_bits;

  assign unused_bits = ^{mmioInData[31:16], mmioAddr[1:0]};

  assign req   = (mmioOpm[4] | mmioOpm[3]) && (mmioAddr[31:4] == BASE_ADDR[31:4]);
  assign sel   = mmioAddr[3:2];
  assign is_wr = mmioOpm[4];
  assign is_rd = mmioOpm[3] & ~mmioOpm[4];
  // Side effects fire only on the IDLE->DONE edge of a well-formed access.
  assign acc     = (bus_q == BUS_IDLE) && req && (mmioOpm[2:0] == 3'b010);
  assign wr_data = acc && is_wr && (sel == 2'd0);
  assign wr_stat = acc && is_wr && (sel == 2'd1);
  assign wr_div  = acc && is_wr && (sel == 2'd2);
  assign rd_data = acc && is_rd && (sel == 2'd0);

  assign status = {25'h0, rx_ferr_q, tx_drop_q, tx_busy_q, rx_ovr_q, rx_vld_q, tx_empty, tx_full};

  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      2'd0:    rd_mux = {23'h0, rx_vld_q, rx_byte_q};
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {16'h0, div_q};
      default: rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    bus_d   = bus_q;
    fault_d = fault_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    mmioOK  = OK_READY;
    case (bus_q)
      BUS_IDLE: if (req) begin
        mmioOK  = OK_HOLD;
        bus_d   = BUS_DONE;
        fault_d = (mmioOpm[2:0] != 3'b010);
        wr_d    = is_wr;
        rdata_d = (acc && is_rd) ? rd_mux : 32'h0;
      end
      BUS_DONE: begin
        if (mmioOpm[4:3] != 2'b00) mmioOK = fault_q ? OK_FAULT : OK_OK;
        else                       bus_d  = BUS_IDLE;
      end
      default: bus_d = BUS_IDLE;
    endcase
  end

  assign mmioOutData = (bus_q == BUS_DONE && !wr_q) ? rdata_q : 32'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_q   <= BUS_IDLE;
      fault_q <= 1'b0;
      wr_q    <= 1'b0;
      div_q   <= DIV_INIT;
    end else begin
      bus_q   <= bus_d;
      fault_q <= fault_d;
      wr_q    <= wr_d;
      if (wr_div) div_q <= mmioInData[15:0];
    end
  end

  always_ff @(posedge clock) rdata_q <= rdata_d;

  // TX FIFO and serializer; a pop on the stop bit's last clock chains frames gap-free.
  assign tx_full  = (txf_cnt_q == TXF_FULL);
  assign tx_empty = (txf_cnt_q == '0);
  assign push     = wr_data && !tx_full;
  assign drop     = wr_data && tx_full;
  assign tx_last  = tx_busy_q && (tx_cnt_q == tx_div_q) && (tx_bit_q == 4'd9);
  assign pop      = (!tx_busy_q || tx_last) && !tx_empty;

  always_ff @(posedge clock) begin
    if (push) txf_mem[txf_wp_q] <= mmioInData[7:0];
    if (pop) begin
      tx_sh_q  <= {1'b1, txf_mem[txf_rp_q], 1'b0};
      tx_div_q <= div_q;
    end else if (tx_busy_q && tx_cnt_q == tx_div_q) begin
      tx_sh_q  <= tx_sh_q >> 1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      txf_wp_q  <= '0;
      txf_rp_q  <= '0;
      txf_cnt_q <= '0;
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      if (push) txf_wp_q <= txf_wp_q + 1'b1;
      if (pop)  txf_rp_q <= txf_rp_q + 1'b1;
      case ({push, pop})
        2'b10:   txf_cnt_q <= txf_cnt_q + 1'b1;
        2'b01:   txf_cnt_q <= txf_cnt_q - 1'b1;
        default: txf_cnt_q <= txf_cnt_q;
      endcase
      if (pop) begin
        tx_busy_q <= 1'b1;
        tx_cnt_q  <= '0;
        tx_bit_q  <= '0;
      end else if (tx_busy_q) begin
        if (tx_cnt_q == tx_div_q) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
          else                  tx_bit_q  <= tx_bit_q + 1'b1;
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      end
      if (drop)                           tx_drop_q <= 1'b1;
      else if (wr_stat && mmioInData[5]) tx_drop_q <= 1'b0;
    end
  end

  assign uartTx = tx_busy_q ? tx_sh_q[0] : 1'b1;

  // RX: falling edge, half-bit wait to recheck the start bit, then one sample per bit period.
  assign rx_div_p1 = {1'b0, div_q} + 17'd1;
  assign rx_half   = rx_div_p1[16:1];
  assign rx_fall   = rx_s3_q && !rx_s2_q;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_div_d = rx_div_q;
    rx_ok    = 1'b0;
    rx_err   = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (rx_fall) begin
        rx_div_d = div_q;
        rx_bit_d = '0;
        if (rx_half == '0) begin
          rx_st_d  = RX_DATA;
          rx_cnt_d = div_q;
        end else begin
          rx_st_d  = RX_START;
          rx_cnt_d = rx_half;
        end
      end
      RX_START: begin
        if (rx_cnt_q <= 16'd1) begin
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
          rx_cnt_d = rx_div_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = rx_div_q;
          if (rx_bit_q == 3'd7) rx_st_d  = RX_STOP;
          else                  rx_bit_d = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_st_d = RX_IDLE;
          rx_ok   = rx_s2_q;
          rx_err  = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    rx_cnt_q <= rx_cnt_d;
    rx_bit_q <= rx_bit_d;
    rx_sh_q  <= rx_sh_d;
    rx_div_q <= rx_div_d;
    if (rx_ok) rx_byte_q <= rx_sh_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_vld_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_s1_q <= uartRx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      rx_st_q <= rx_st_d;
      // A completing byte wins over a same-cycle DATA read clearing rxValid.
      if (rx_ok)        rx_vld_q <= 1'b1;
      else if (rd_data) rx_vld_q <= 1'b0;
      if (rx_ok && rx_vld_q && !rd_data)  rx_ovr_q <= 1'b1;
      else if (wr_stat && mmioInData[3]) rx_ovr_q <= 1'b0;
      if (rx_err)                         rx_ferr_q <= 1'b1;
      else if (wr_stat && mmioInData[6]) rx_ferr_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bsr_mmio_uart.sv
// Directed bench for bsr_mmio_uart: bus handshake, TX framing via a bit
// scoreboard, FIFO overflow, RX framing/overrun/frame error, fault decode.
module tb_bsr_mmio_uart;
  localparam logic [1:0] READY = 2'b00, OK = 2'b01, HOLD = 2'b10, FAULT = 2'b11;
  localparam logic [31:0] A_DATA = 32'hE010, A_STAT = 32'hE014, A_DIV = 32'hE018;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mmioAddr, mmioInData, mmioOutData;
  logic [4:0]  mmioOpm;
  logic [1:0]  mmioOK;
  logic        uartTx, uartRx;

  int   total = 0;
  int   bad = 0;
  logic tx_q[$];
  logic tx_done = 1'b0;
  logic m_rxv = 1'b0;
  logic [7:0] m_byte = 8'h00;

  bsr_mmio_uart dut (
    .clock(clock), .reset(reset), .mmioAddr(mmioAddr), .mmioOpm(mmioOpm),
    .mmioInData(mmioInData), .mmioOutData(mmioOutData), .mmioOK(mmioOK),
    .uartTx(uartTx), .uartRx(uartRx)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mmio(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size,
                      input logic [1:0] exp_ok, input logic [31:0] exp_data);
    @(negedge clock);
    mmioAddr   = addr;
    mmioInData = wdata;
    mmioOpm    = {wr, ~wr, size};
    #1;
    chk({tag, "_phase1_ok"}, 32'(mmioOK), (exp_ok == READY) ? 32'(READY) : 32'(HOLD));
    @(posedge clock);
    #1;
    chk({tag, "_ok"}, 32'(mmioOK), 32'(exp_ok));
    chk({tag, "_data"}, mmioOutData, exp_data);
    mmioOpm = 5'b0;
    #1;
    chk({tag, "_release_ok"}, 32'(mmioOK), 32'(READY));
    @(posedge clock);
    #1;
  endtask

  task automatic tx_mon();
    bit   found = 1'b0;
    logic expb = 1'b1;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clock);
      if (uartTx == 1'b0) found = 1'b1;
    end
    chk("tx_start_seen", 32'(found), 32'd1);
    if (found) begin
      for (int i = 0; i < 40; i++) begin
        if (i > 0) @(negedge clock);
        if (i % 4 == 0) expb = tx_q.pop_front();
        chk("tx_bit", 32'(uartTx), 32'(expb));
      end
      @(negedge clock);
      chk("tx_idle_after", 32'(uartTx), 32'd1);
    end
    tx_done = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      uartRx = f[i];
      repeat (4) @(negedge clock);
    end
    uartRx = 1'b1;
    repeat (8) @(negedge clock);
    if (stop_bit) begin
      m_rxv  = 1'b1;
      m_byte = b;
    end
  endtask

  task automatic rx_read(input string tag);
    mmio(tag, 1'b0, A_DATA, 32'h0, 3'b010, OK, {23'h0, m_rxv, m_byte});
    m_rxv = 1'b0;
  endtask

  initial begin
    logic [7:0] txb;
    uartRx = 1'b1; mmioOpm = 5'b0; mmioAddr = 32'h0; mmioInData = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ok", 32'(mmioOK), 32'(READY));
    chk("rst_data", mmioOutData, 32'h0);
    chk("rst_tx", 32'(uartTx), 32'd1);
    @(negedge clock);
    reset = 1'b0;

    mmio("stat_reset", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0002);
    mmio("div_wr", 1'b1, A_DIV, 32'd3, 3'b010, OK, 32'h0);
    mmio("div_rd", 1'b0, A_DIV, 32'h0, 3'b010, OK, 32'd3);

    // TX frame of A5: start, LSB-first data, stop
    txb = 8'hA5;
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(txb[i]);
    tx_q.push_back(1'b1);
    fork tx_mon(); join_none
    mmio("tx_wr_a5", 1'b1, A_DATA, 32'hA5, 3'b010, OK, 32'h0);
    mmio("stat_txbusy", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0012);
    for (int k = 0; k < 100 && !tx_done; k++) @(posedge clock);
    chk("tx_done", 32'(tx_done), 32'd1);
    mmio("stat_txidle", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0002);

    // FIFO overflow with a slow frame in flight
    mmio("div_slow", 1'b1, A_DIV, 32'd200, 3'b010, OK, 32'h0);
    for (int i = 0; i < 17; i++) mmio("fill", 1'b1, A_DATA, 32'(i), 3'b010, OK, 32'h0);
    mmio("stat_full", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0011);
    mmio("wr_drop", 1'b1, A_DATA, 32'hEE, 3'b010, OK, 32'h0);
    mmio("stat_drop", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0031);
    mmio("clr_drop", 1'b1, A_STAT, 32'h20, 3'b010, OK, 32'h0);
    mmio("stat_dropclr", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0011);

    // reset mid-frame
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_tx", 32'(uartTx), 32'd1);
    chk("midrst_ok", 32'(mmioOK), 32'(READY));
    @(negedge clock);
    reset = 1'b0;
    mmio("stat_after_rst", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0002);
    mmio("div_after_rst", 1'b0, A_DIV, 32'h0, 3'b010, OK, 32'd433);
    mmio("div_wr2", 1'b1, A_DIV, 32'd3, 3'b010, OK, 32'h0);

    // RX
    rx_frame(8'h3C, 1'b1);
    mmio("stat_rxv", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0006);
    rx_read("rx_read1");
    rx_read("rx_read2");
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    rx_frame(8'h55, 1'b0);
    mmio("stat_ovr_ferr", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_004E);
    rx_read("rx_read_ovr");
    mmio("clr_sticky", 1'b1, A_STAT, 32'h48, 3'b010, OK, 32'h0);
    mmio("stat_clr", 1'b0, A_STAT, 32'h0, 3'b010, OK, 32'h0000_0002);

    // bad size and out-of-window
    mmio("fault_rd", 1'b0, A_STAT, 32'h0, 3'b011, FAULT, 32'h0);
    mmio("fault_wr", 1'b1, A_DIV, 32'd7, 3'b011, FAULT, 32'h0);
    mmio("div_unchanged", 1'b0, A_DIV, 32'h0, 3'b010, OK, 32'd3);
    mmio("nomatch", 1'b0, 32'hE020, 32'h0, 3'b010, READY, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
